// File: rtl/ula_fx_pkg.sv
// Shared definitions for the ula_fx arbiter: op codes, FSM states and op helpers.
package ula_fx_pkg;

  localparam int unsigned OP_W = 5;

  localparam logic [OP_W-1:0] OP_NOP = 5'd0;
  localparam logic [OP_W-1:0] OP_MOV = 5'd1;
  localparam logic [OP_W-1:0] OP_ADD = 5'd2;
  localparam logic [OP_W-1:0] OP_SUB = 5'd3;
  localparam logic [OP_W-1:0] OP_DIV = 5'd4;
  localparam logic [OP_W-1:0] OP_MOD = 5'd5;
  localparam logic [OP_W-1:0] OP_MUL = 5'd6;
  localparam logic [OP_W-1:0] OP_AND = 5'd7;
  localparam logic [OP_W-1:0] OP_OR  = 5'd8;
  localparam logic [OP_W-1:0] OP_XOR = 5'd9;
  localparam logic [OP_W-1:0] OP_NOT = 5'd10;
  localparam logic [OP_W-1:0] OP_SHL = 5'd11;
  localparam logic [OP_W-1:0] OP_SHR = 5'd12;
  localparam logic [OP_W-1:0] OP_SRA = 5'd13;
  localparam logic [OP_W-1:0] OP_NEG = 5'd14;
  localparam logic [OP_W-1:0] OP_ABS = 5'd15;
  localparam logic [OP_W-1:0] OP_INC = 5'd16;
  localparam logic [OP_W-1:0] OP_DEC = 5'd17;
  localparam logic [OP_W-1:0] OP_LT  = 5'd18;
  localparam logic [OP_W-1:0] OP_GE  = 5'd19;
  localparam logic [OP_W-1:0] OP_EQ  = 5'd20;
  localparam logic [OP_W-1:0] OP_NE  = 5'd21;
  localparam logic [OP_W-1:0] OP_SLS = 5'd22;
  localparam logic [OP_W-1:0] OP_SRS = 5'd23;
  localparam logic [OP_W-1:0] OP_LAST = OP_SRS;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  // DIV and MOD occupy the shared ULA for the long hold window.
  function automatic logic is_divmod(input logic [OP_W-1:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/ula_fx_rr.sv
// Round-robin picker: first set request after the last granted index, wrapping.
module ula_fx_rr #(
  parameter int unsigned NREQ  = 2,
  parameter int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [IDX_W-1:0] last_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  always_comb begin
    int unsigned cand;
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 32'(last_i) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any_o && req_i[IDX_W'(cand)]) begin
        any_o                 = 1'b1;
        idx_o                 = IDX_W'(cand);
        gnt_o[IDX_W'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ula_fx_arb.sv
// Arbiter sharing one ula_fx between NREQ requesters: grant, drive ULA, return result.
// Optional ULA_FX_ARB_ERR_EN adds res_err and rejects illegal ops / divide by zero.
module ula_fx_arb
  import ula_fx_pkg::*;
#(
  parameter int unsigned NUBITS   = 32,
  parameter int unsigned NREQ     = 2,
  parameter int unsigned DIV_WAIT = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_vld,
  output logic [NREQ-1:0]        req_rdy,
  input  logic [OP_W*NREQ-1:0]   req_op,
  input  logic [NUBITS*NREQ-1:0] req_in1,
  input  logic [NUBITS*NREQ-1:0] req_in2,
  output logic [NREQ-1:0]        res_vld,
  output logic [NUBITS-1:0]      res_out,
  output logic                   res_zero,
`ifdef ULA_FX_ARB_ERR_EN
  output logic                   res_err,
`endif
  output logic [OP_W-1:0]        ula_op,
  output logic [NUBITS-1:0]      ula_in1,
  output logic [NUBITS-1:0]      ula_in2,
  input  logic [NUBITS-1:0]      ula_out,
  input  logic                   ula_zero,
  output logic                   busy
);

  localparam int unsigned IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CNT_W = (DIV_WAIT > 1) ? $clog2(DIV_WAIT) : 1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   last_q, last_d;
  logic [NREQ-1:0]    gnt_q, gnt_d;
  logic [OP_W-1:0]    op_q, op_d;
  logic [NUBITS-1:0]  in1_q, in1_d;
  logic [NUBITS-1:0]  in2_q, in2_d;
  logic [NUBITS-1:0]  res_q, res_d;
  logic               res_zero_q, res_zero_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0]    rr_gnt;
  logic [IDX_W-1:0]   rr_idx;
  logic               rr_any;
  logic               take;
  logic [OP_W-1:0]    sel_op;
  logic [NUBITS-1:0]  sel_in1;
  logic [NUBITS-1:0]  sel_in2;

`ifdef ULA_FX_ARB_ERR_EN
  logic               res_err_q, res_err_d;
  logic               flag;
`endif

  ula_fx_rr #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req_i  (req_vld),
    .last_i (last_q),
    .gnt_o  (rr_gnt),
    .idx_o  (rr_idx),
    .any_o  (rr_any)
  );

  // Operand mux for the winning requester.
  always_comb begin
    sel_op  = '0;
    sel_in1 = '0;
    sel_in2 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (rr_idx == IDX_W'(i)) begin
        sel_op  = req_op[OP_W*i +: OP_W];
        sel_in1 = req_in1[NUBITS*i +: NUBITS];
        sel_in2 = req_in2[NUBITS*i +: NUBITS];
      end
    end
  end

  // Grant is suppressed while reset is held so req_rdy reads 0 immediately.
  assign take = rst && (state_q == IDLE) && rr_any;

`ifdef ULA_FX_ARB_ERR_EN
  assign flag = (sel_op > OP_LAST) || (is_divmod(sel_op) && (sel_in2 == '0));
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (take) begin
`ifdef ULA_FX_ARB_ERR_EN
          state_d = flag ? RESP : EXEC;
`else
          state_d = EXEC;
`endif
        end
      end
      EXEC:    if (cnt_q == '0) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_rdy = '0;
    res_vld = '0;
    ula_op  = OP_NOP;
    busy    = 1'b0;
    if (take) req_rdy = rr_gnt;
    if (state_q == EXEC) ula_op = op_q;
    if (state_q == RESP) res_vld = gnt_q;
    if (state_q != IDLE) busy = 1'b1;
  end

  // Request latch, hold counter and result capture.
  always_comb begin
    last_d     = last_q;
    gnt_d      = gnt_q;
    op_d       = op_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    cnt_d      = cnt_q;
    res_d      = res_q;
    res_zero_d = res_zero_q;
`ifdef ULA_FX_ARB_ERR_EN
    res_err_d  = res_err_q;
`endif
    if (take) begin
      last_d = rr_idx;
      gnt_d  = rr_gnt;
`ifdef ULA_FX_ARB_ERR_EN
      if (flag) begin
        res_d      = '0;
        res_zero_d = 1'b1;
        res_err_d  = 1'b1;
      end else begin
        op_d  = sel_op;
        in1_d = sel_in1;
        in2_d = sel_in2;
        cnt_d = is_divmod(sel_op) ? CNT_W'(DIV_WAIT - 1) : '0;
      end
`else
      op_d  = sel_op;
      in1_d = sel_in1;
      in2_d = sel_in2;
      cnt_d = is_divmod(sel_op) ? CNT_W'(DIV_WAIT - 1) : '0;
`endif
    end else if (state_q == EXEC) begin
      if (cnt_q == '0) begin
        res_d      = ula_out;
        res_zero_d = ula_zero;
`ifdef ULA_FX_ARB_ERR_EN
        res_err_d  = 1'b0;
`endif
      end else begin
        cnt_d = cnt_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_q     <= IDX_W'(NREQ - 1);
      gnt_q      <= '0;
      op_q       <= '0;
      in1_q      <= '0;
      in2_q      <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      res_zero_q <= 1'b0;
`ifdef ULA_FX_ARB_ERR_EN
      res_err_q  <= 1'b0;
`endif
    end else begin
      last_q     <= last_d;
      gnt_q      <= gnt_d;
      op_q       <= op_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      cnt_q      <= cnt_d;
      res_q      <= res_d;
      res_zero_q <= res_zero_d;
`ifdef ULA_FX_ARB_ERR_EN
      res_err_q  <= res_err_d;
`endif
    end
  end

  assign res_out  = res_q;
  assign res_zero = res_zero_q;
  assign ula_in1  = in1_q;
  assign ula_in2  = in2_q;
`ifdef ULA_FX_ARB_ERR_EN
  assign res_err  = res_err_q;
`endif

endmodule

// File: tb/tb_ula_fx_arb.sv
// Bench for ula_fx_arb: timeline model of grants/latencies plus directed literal checks.
module tb_ula_fx_arb;

  localparam int unsigned NUBITS   = 32;
  localparam int unsigned NREQ     = 2;
  localparam int unsigned DIV_WAIT = 4;

  logic                   clk = 1'b0;
  logic                   rst = 1'b0;
  logic [NREQ-1:0]        req_vld = '0;
  logic [NREQ-1:0]        req_rdy;
  logic [5*NREQ-1:0]      req_op = '0;
  logic [NUBITS*NREQ-1:0] req_in1 = '0;
  logic [NUBITS*NREQ-1:0] req_in2 = '0;
  logic [NREQ-1:0]        res_vld;
  logic [NUBITS-1:0]      res_out;
  logic                   res_zero;
`ifdef ULA_FX_ARB_ERR_EN
  logic                   res_err;
`endif
  logic [4:0]             ula_op;
  logic [NUBITS-1:0]      ula_in1, ula_in2, ula_out;
  logic                   ula_zero;
  logic                   busy;

  int n_total = 0;
  int n_pass  = 0;
  int tcyc    = 0;

  ula_fx_arb #(.NUBITS(NUBITS), .NREQ(NREQ), .DIV_WAIT(DIV_WAIT)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_op(req_op),
    .req_in1(req_in1), .req_in2(req_in2),
    .res_vld(res_vld), .res_out(res_out), .res_zero(res_zero),
`ifdef ULA_FX_ARB_ERR_EN
    .res_err(res_err),
`endif
    .ula_op(ula_op), .ula_in1(ula_in1), .ula_in2(ula_in2),
    .ula_out(ula_out), .ula_zero(ula_zero), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) tcyc <= tcyc + 1;

  // Stand-in for the shared ULA (signed add/sub/div/mod; others xor).
  function automatic logic [31:0] env_alu(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [31:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      5'd2:    return a + b;
      5'd3:    return a - b;
      5'd4:    return (b == 0) ? 32'd0 : 32'(sa / sb);
      5'd5:    return (b == 0) ? 32'd0 : 32'(sa % sb);
      default: return a ^ b;
    endcase
  endfunction

  always_comb begin
    ula_out  = env_alu(ula_op, ula_in1, ula_in2);
    ula_zero = (ula_out == '0);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, tcyc);
  endtask

  task automatic fail_timeout(input string name);
    n_total++;
    $display("FAIL %s: got no event want event within budget (cycle %0d)", name, tcyc);
  endtask

  // Timeline model: a grant at cycle g owns the ULA for g+1..g+L-1 and strobes at g+L.
  int          m_last = NREQ - 1, m_g = 0, g_cyc = -1000, lat = 2, free_at = 0;
  logic        m_flag = 1'b0;
  logic [4:0]  m_op = '0;
  logic [31:0] m_a = '0, m_b = '0, m_res = '0;
  logic [31:0] e_in1 = '0, e_in2 = '0, e_res = '0;
  logic        e_zero = 1'b0, e_err = 1'b0;

  always @(negedge clk) begin
    logic [1:0] e_rdy, e_vld;
    logic [4:0] e_op;
    logic       e_busy;
    int         pick, c;
    e_rdy = '0; e_vld = '0; e_op = '0; e_busy = 1'b0; pick = -1;
    if (!rst) begin
      m_last = NREQ - 1; g_cyc = -1000; lat = 2; free_at = 0; m_flag = 1'b0;
      e_in1 = '0; e_in2 = '0; e_res = '0; e_zero = 1'b0; e_err = 1'b0;
    end else begin
      if (tcyc >= free_at && req_vld != '0) begin
        for (int k = 1; k <= NREQ; k++) begin
          c = (m_last + k) % NREQ;
          if (pick < 0 && ((req_vld >> c) & 1) != 0) pick = c;
        end
        m_g = pick; m_last = pick; g_cyc = tcyc;
        m_op = 5'(req_op >> (5 * pick));
        m_a  = 32'(req_in1 >> (32 * pick));
        m_b  = 32'(req_in2 >> (32 * pick));
        m_flag = 1'b0;
`ifdef ULA_FX_ARB_ERR_EN
        m_flag = (m_op > 5'd23) || ((m_op == 5'd4 || m_op == 5'd5) && m_b == 0);
`endif
        if (m_flag) begin
          lat = 1; m_res = '0;
        end else begin
          lat = (m_op == 5'd4 || m_op == 5'd5) ? 1 + DIV_WAIT : 2;
          m_res = env_alu(m_op, m_a, m_b);
        end
        free_at = g_cyc + lat + 1;
        e_rdy = 2'(1 << pick);
      end
      if (tcyc > g_cyc && tcyc < g_cyc + lat) e_op = m_op;
      if (tcyc == g_cyc + 1 && !m_flag) begin e_in1 = m_a; e_in2 = m_b; end
      if (tcyc == g_cyc + lat) begin
        e_vld = 2'(1 << m_g); e_res = m_res; e_zero = (m_res == 0); e_err = m_flag;
      end
      e_busy = (tcyc > g_cyc) && (tcyc <= g_cyc + lat);
    end
    check("req_rdy", req_rdy, e_rdy);
    check("res_vld", res_vld, e_vld);
    check("ula_op", ula_op, e_op);
    check("ula_in1", ula_in1, e_in1);
    check("ula_in2", ula_in2, e_in2);
    check("res_out", res_out, e_res);
    check("res_zero", res_zero, e_zero);
    check("busy", busy, e_busy);
`ifdef ULA_FX_ARB_ERR_EN
    check("res_err", res_err, e_err);
`endif
  end

  task automatic request(input int r, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, output int g);
    @(posedge clk); #1;
    req_op[5*r +: 5] = op;
    req_in1[32*r +: 32] = a;
    req_in2[32*r +: 32] = b;
    req_vld[r] = 1'b1;
    g = -1;
    for (int k = 0; k < 40 && g < 0; k++) begin
      @(negedge clk); #1;
      if (req_rdy[r]) g = tcyc;
    end
    if (g < 0) fail_timeout("grant");
    @(posedge clk); #1;
    req_vld[r] = 1'b0;
  endtask

  task automatic wait_vld(input int r, input logic [4:0] op, output int nops, output int v);
    nops = 0; v = -1;
    for (int k = 0; k < 40 && v < 0; k++) begin
      @(negedge clk); #1;
      if (res_vld[r]) v = tcyc;
      else if (ula_op == op) nops++;
    end
    if (v < 0) fail_timeout("res_vld");
  endtask

  task automatic do_op(input int r, input logic [4:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] x_out, input logic x_zero,
                       input int x_lat, input int x_nops, input string nm);
    int g, v, n;
    request(r, op, a, b, g);
    wait_vld(r, op, n, v);
    check({nm, "_lat"}, 64'(v - g), 64'(x_lat));
    check({nm, "_opcycles"}, 64'(n), 64'(x_nops));
    check({nm, "_out"}, res_out, x_out);
    check({nm, "_zero"}, res_zero, x_zero);
  endtask

  initial begin
    int gi[8], gc[8], vi[8], vc[8];
    int ng, nv, g, v, n;
    ng = 0; nv = 0;

    repeat (3) @(negedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_last_res", res_out, 0);

    // Both requesters hold requests continuously from reset release.
    @(posedge clk); #1;
    rst = 1'b1;
    req_op  = {5'd2, 5'd3};
    req_in1 = {32'd1, 32'd9};
    req_in2 = {32'd2, 32'd4};
    req_vld = 2'b11;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      if (req_rdy != '0 && ng < 8) begin gi[ng] = req_rdy[1] ? 1 : 0; gc[ng] = tcyc; ng++; end
      if (res_vld != '0 && nv < 8) begin vi[nv] = res_vld[1] ? 1 : 0; vc[nv] = tcyc; nv++; end
    end
    @(posedge clk); #1;
    req_vld = '0;
    check("rr_ngrants", 64'(ng), 4);
    check("rr_nresults", 64'(nv), 4);
    for (int k = 0; k < 4 && k < ng && k < nv; k++) begin
      check("rr_order", 64'(gi[k]), 64'(k % 2));
      check("rr_res_idx", 64'(vi[k]), 64'(k % 2));
      check("rr_res_lat", 64'(vc[k] - gc[k]), 2);
      if (k > 0) check("rr_spacing", 64'(gc[k] - gc[k-1]), 3);
    end

    do_op(0, 5'd2, 32'd5,   32'd7,          32'd12,         1'b0, 2, 1, "add");
    do_op(1, 5'd4, 32'd100, 32'd7,          32'd14,         1'b0, 5, 4, "div");
    do_op(0, 5'd5, 32'd100, 32'd7,          32'd2,          1'b0, 5, 4, "mod");
    do_op(1, 5'd2, 32'd5,   32'hFFFF_FFFB,  32'd0,          1'b1, 2, 1, "add_zero");

    // A request raised and withdrawn while busy is never granted.
    request(0, 5'd2, 32'd1, 32'd1, g);
    req_op[9:5] = 5'd5; req_in1[63:32] = 32'd100; req_in2[63:32] = 32'd7;
    req_vld[1] = 1'b1;
    @(posedge clk); #1;
    req_vld[1] = 1'b0;
    @(negedge clk); #1;
    check("drop_resvld", res_vld, 2'b01);
    check("drop_res", res_out, 32'd2);
    @(negedge clk); #1;
    check("drop_norgrant", req_rdy, 2'b00);
    check("drop_idle", busy, 1'b0);

    do_op(0, 5'd3, 32'd3, 32'd10, 32'hFFFF_FFF9, 1'b0, 2, 1, "sub_neg");

    // Reset in the middle of a DIV hold.
    request(0, 5'd4, 32'd100, 32'd7, g);
    @(posedge clk); #1;
    rst = 1'b0;
    req_op  = {5'd3, 5'd2};
    req_in1 = {32'd3, 32'd1};
    req_in2 = {32'd1, 32'd1};
    req_vld = 2'b11;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_ula_op", ula_op, 5'd0);
    check("arst_ula_in1", ula_in1, 32'd0);
    check("arst_res_out", res_out, 32'd0);
    check("arst_rdy", req_rdy, 2'b00);
    repeat (2) begin
      @(negedge clk); #1;
      check("arst_no_vld", res_vld, 2'b00);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk); #1;
    check("arst_first_grant", req_rdy, 2'b01);
    @(posedge clk); #1;
    req_vld[0] = 1'b0;
    wait_vld(0, 5'd2, n, v);
    check("arst_r0_res", res_out, 32'd2);
    request(1, 5'd3, 32'd3, 32'd1, g);
    wait_vld(1, 5'd3, n, v);
    check("arst_r1_res", res_out, 32'd2);

`ifdef ULA_FX_ARB_ERR_EN
    do_op(1, 5'd25, 32'd3, 32'd5, 32'd0, 1'b1, 1, 0, "op25");
    check("op25_err", res_err, 1'b1);
    do_op(0, 5'd4, 32'd9, 32'd0, 32'd0, 1'b1, 1, 0, "div0");
    check("div0_err", res_err, 1'b1);
    do_op(1, 5'd2, 32'd4, 32'd4, 32'd8, 1'b0, 2, 1, "after_err");
    check("after_err_err", res_err, 1'b0);
`else
    do_op(1, 5'd25, 32'd3, 32'd5, 32'd6, 1'b0, 2, 1, "op25");
    do_op(0, 5'd4, 32'd9, 32'd0, 32'd0, 1'b1, 5, 4, "div0");
`endif

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test want end before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
